// File: rtl/gesture_decider.sv
// Turns per-window motion deltas into confirmed swipe gestures: a registered
// qualify/classify stage followed by a confirm/emit/cooldown FSM.
module gesture_decider #(
    parameter int ACC_SUM_BITS     = 18,
    parameter int ACC_COUNT_BITS   = 12,
    parameter int MIN_EVENTS       = 20,
    parameter int MIN_DELTA        = 64,
    parameter int DOM_SHIFT        = 1,
    parameter int CONFIRM_COUNT    = 2,
    parameter int COOLDOWN_WINDOWS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic signed [ACC_SUM_BITS-1:0]   delta_x,
    input  logic signed [ACC_SUM_BITS-1:0]   delta_y,
    input  logic        [ACC_SUM_BITS-1:0]   abs_delta_x,
    input  logic        [ACC_SUM_BITS-1:0]   abs_delta_y,
    input  logic        [ACC_COUNT_BITS-1:0] total_events,
    output logic                             gesture_valid,
    input  logic                             gesture_ready,
    output logic        [1:0]                gesture_class,
    output logic        [ACC_SUM_BITS-1:0]   gesture_strength,
    output logic                             busy,
    output logic        [7:0]                dropped_count
);

    localparam int STREAK_W = $clog2(CONFIRM_COUNT + 1);
    localparam int COOL_W   = (COOLDOWN_WINDOWS > 0) ? $clog2(COOLDOWN_WINDOWS + 1) : 1;

    localparam logic [STREAK_W-1:0]       CONFIRM_TGT = STREAK_W'(CONFIRM_COUNT);
    localparam logic [COOL_W-1:0]         COOL_LOAD   = COOL_W'(COOLDOWN_WINDOWS);
    localparam logic [ACC_COUNT_BITS-1:0] MIN_EV      = ACC_COUNT_BITS'(MIN_EVENTS);
    localparam logic [ACC_SUM_BITS-1:0]   MIN_MAG     = ACC_SUM_BITS'(MIN_DELTA);

    localparam logic [1:0] CLS_RIGHT = 2'd0;
    localparam logic [1:0] CLS_LEFT  = 2'd1;
    localparam logic [1:0] CLS_UP    = 2'd2;
    localparam logic [1:0] CLS_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_EMIT     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    logic                    x_major_s;
    logic [ACC_SUM_BITS-1:0] major_s;
    logic [ACC_SUM_BITS-1:0] minor_s;
    logic [ACC_SUM_BITS:0]   dom_sum_s;
    logic [1:0]              class_s;
    logic                    qual_s;
    logic                    pos_x_s;
    logic                    pos_y_s;

    logic                    cand_valid_r;
    logic                    cand_qual_r;
    logic [1:0]              cand_class_r;
    logic [ACC_SUM_BITS-1:0] cand_mag_r;

    state_t                  state_r;
    logic [STREAK_W-1:0]     streak_r;
    logic [COOL_W-1:0]       cooldown_r;
    logic [1:0]              latch_class_r;
    logic                    gesture_valid_r;
    logic [1:0]              gesture_class_r;
    logic [ACC_SUM_BITS-1:0] gesture_strength_r;
    logic                    busy_r;
    logic [7:0]              dropped_r;

    // Window qualification: pick the major axis (ties go to x) and test the thresholds
    always_comb begin
        pos_x_s   = ~delta_x[ACC_SUM_BITS-1] & (|delta_x);
        pos_y_s   = ~delta_y[ACC_SUM_BITS-1] & (|delta_y);
        x_major_s = (abs_delta_x >= abs_delta_y);
        if (x_major_s) begin
            major_s = abs_delta_x;
            minor_s = abs_delta_y;
            class_s = pos_x_s ? CLS_RIGHT : CLS_LEFT;
        end else begin
            major_s = abs_delta_y;
            minor_s = abs_delta_x;
            class_s = pos_y_s ? CLS_DOWN : CLS_UP;
        end
        // One extra bit so minor + minor/2^k cannot wrap
        dom_sum_s = {1'b0, minor_s} + ({1'b0, minor_s} >> DOM_SHIFT);
        qual_s    = (total_events >= MIN_EV) && (major_s >= MIN_MAG) &&
                    ({1'b0, major_s} > dom_sum_s);
    end

    // Stage 1 candidate register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_valid_r <= 1'b0;
            cand_qual_r  <= 1'b0;
            cand_class_r <= 2'd0;
            cand_mag_r   <= {ACC_SUM_BITS{1'b0}};
        end else begin
            cand_valid_r <= in_valid;
            if (in_valid) begin
                cand_qual_r  <= qual_s;
                cand_class_r <= class_s;
                cand_mag_r   <= major_s;
            end
        end
    end

    // Stage 2 confirm/emit/cooldown FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            streak_r           <= {STREAK_W{1'b0}};
            cooldown_r         <= {COOL_W{1'b0}};
            latch_class_r      <= 2'd0;
            gesture_valid_r    <= 1'b0;
            gesture_class_r    <= 2'd0;
            gesture_strength_r <= {ACC_SUM_BITS{1'b0}};
            busy_r             <= 1'b0;
            dropped_r          <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cand_valid_r && cand_qual_r) begin
                        latch_class_r <= cand_class_r;
                        busy_r        <= 1'b1;
                        if (CONFIRM_COUNT == 1) begin
                            streak_r           <= {STREAK_W{1'b0}};
                            state_r            <= ST_EMIT;
                            gesture_valid_r    <= 1'b1;
                            gesture_class_r    <= cand_class_r;
                            gesture_strength_r <= cand_mag_r;
                        end else begin
                            streak_r <= STREAK_W'(1);
                            state_r  <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (cand_valid_r) begin
                        if (!cand_qual_r) begin
                            streak_r <= {STREAK_W{1'b0}};
                            state_r  <= ST_IDLE;
                            busy_r   <= 1'b0;
                        end else if (cand_class_r == latch_class_r) begin
                            if (streak_r == CONFIRM_TGT - STREAK_W'(1)) begin
                                streak_r           <= {STREAK_W{1'b0}};
                                state_r            <= ST_EMIT;
                                gesture_valid_r    <= 1'b1;
                                gesture_class_r    <= cand_class_r;
                                gesture_strength_r <= cand_mag_r;
                            end else begin
                                streak_r <= streak_r + STREAK_W'(1);
                            end
                        end else begin
                            latch_class_r <= cand_class_r;
                            streak_r      <= STREAK_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    // A window landing on the handshake cycle still counts as an EMIT window
                    if (cand_valid_r && cand_qual_r && (dropped_r != 8'hFF)) begin
                        dropped_r <= dropped_r + 8'd1;
                    end
                    if (gesture_valid_r && gesture_ready) begin
                        gesture_valid_r <= 1'b0;
                        if (COOLDOWN_WINDOWS == 0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            cooldown_r <= COOL_LOAD;
                            state_r    <= ST_COOLDOWN;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (cand_valid_r) begin
                        if (cooldown_r <= COOL_W'(1)) begin
                            cooldown_r <= {COOL_W{1'b0}};
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                        end else begin
                            cooldown_r <= cooldown_r - COOL_W'(1);
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    streak_r        <= {STREAK_W{1'b0}};
                    cooldown_r      <= {COOL_W{1'b0}};
                    gesture_valid_r <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

    assign gesture_valid    = gesture_valid_r;
    assign gesture_class    = gesture_class_r;
    assign gesture_strength = gesture_strength_r;
    assign busy             = busy_r;
    assign dropped_count    = dropped_r;

endmodule

// File: tb/tb_gesture_decider.sv
// Directed scenario tests for gesture_decider with hand-computed expectations.
module tb_gesture_decider;

    localparam int SB = 18;
    localparam int CB = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [SB-1:0] delta_x;
    logic signed [SB-1:0] delta_y;
    logic        [SB-1:0] abs_delta_x;
    logic        [SB-1:0] abs_delta_y;
    logic        [CB-1:0] total_events;
    logic                 gesture_valid;
    logic                 gesture_ready;
    logic        [1:0]    gesture_class;
    logic        [SB-1:0] gesture_strength;
    logic                 busy;
    logic        [7:0]    dropped_count;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    int vcycles  = 0;

    gesture_decider dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .delta_x          (delta_x),
        .delta_y          (delta_y),
        .abs_delta_x      (abs_delta_x),
        .abs_delta_y      (abs_delta_y),
        .total_events     (total_events),
        .gesture_valid    (gesture_valid),
        .gesture_ready    (gesture_ready),
        .gesture_class    (gesture_class),
        .gesture_strength (gesture_strength),
        .busy             (busy),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    // Count handshakes and cycles with gesture_valid high
    always @(posedge clk) begin
        if (gesture_valid === 1'b1) vcycles <= vcycles + 1;
        if (gesture_valid === 1'b1 && gesture_ready === 1'b1) hs_count <= hs_count + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic win(input int dx, input int dy, input int ev);
        in_valid     = 1'b1;
        delta_x      = SB'(dx);
        delta_y      = SB'(dy);
        abs_delta_x  = SB'((dx < 0) ? -dx : dx);
        abs_delta_y  = SB'((dy < 0) ? -dy : dy);
        total_events = CB'(ev);
        step(1);
        in_valid     = 1'b0;
    endtask

    task automatic flush();
        win(0, 0, 0);
        win(0, 0, 0);
        win(0, 0, 0);
        step(2);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_checks++;
        if (gesture_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", gesture_valid);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
        else n_pass++;
        n_checks++;
        if (dropped_count !== 8'd0) $display("FAIL reset_dropped got %0d exp 0", dropped_count);
        else n_pass++;
        n_checks++;
        if (gesture_class !== 2'd0 || gesture_strength !== 18'd0)
            $display("FAIL reset_outputs got class %0d strength %0d exp 0 0", gesture_class, gesture_strength);
        else n_pass++;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic_right();
        int h0, v0;
        gesture_ready = 1'b1;
        h0 = hs_count;
        v0 = vcycles;
        win(200, 30, 100);
        win(200, 30, 100);
        n_checks++;
        if (gesture_valid !== 1'b0) $display("FAIL basic_early got %b exp 0", gesture_valid);
        else n_pass++;
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd0 || gesture_strength !== 18'd200)
            $display("FAIL basic_gesture got v%b c%0d s%0d exp v1 c0 s200", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_after got v%b busy%b exp v0 busy1", gesture_valid, busy);
        else n_pass++;
        n_checks++;
        if (hs_count - h0 != 1 || vcycles - v0 != 1)
            $display("FAIL basic_count got hs %0d vcyc %0d exp 1 1", hs_count - h0, vcycles - v0);
        else n_pass++;
        flush();
    endtask

    task automatic test_min_events();
        int h0;
        h0 = hs_count;
        win(-100, 0, 19);
        win(-100, 0, 19);
        step(3);
        n_checks++;
        if (hs_count != h0 || gesture_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL events19 got hs %0d v%b busy%b exp 0 0 0", hs_count - h0, gesture_valid, busy);
        else n_pass++;
        win(-100, 0, 20);
        win(-100, 0, 20);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd1 || gesture_strength !== 18'd100)
            $display("FAIL events20 got v%b c%0d s%0d exp v1 c1 s100", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        flush();
    endtask

    task automatic test_dominance();
        int h0;
        h0 = hs_count;
        win(120, 80, 100);
        win(120, 80, 100);
        step(3);
        win(63, 0, 100);
        win(63, 0, 100);
        step(3);
        n_checks++;
        if (hs_count != h0 || busy !== 1'b0)
            $display("FAIL dominance_reject got hs %0d busy%b exp 0 0", hs_count - h0, busy);
        else n_pass++;
        win(121, 80, 100);
        win(121, 80, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd0 || gesture_strength !== 18'd121)
            $display("FAIL dominance_accept got v%b c%0d s%0d exp v1 c0 s121", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        flush();
    endtask

    task automatic test_class_change();
        int h0;
        h0 = hs_count;
        win(0, -150, 100);
        win(0, 150, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL change_second got v%b busy%b exp v0 busy1", gesture_valid, busy);
        else n_pass++;
        win(0, 150, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd3 || gesture_strength !== 18'd150)
            $display("FAIL change_third got v%b c%0d s%0d exp v1 c3 s150", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        n_checks++;
        if (hs_count - h0 != 1) $display("FAIL change_count got %0d exp 1", hs_count - h0);
        else n_pass++;
        flush();
    endtask

    task automatic test_backpressure();
        int h0;
        gesture_ready = 1'b0;
        h0 = hs_count;
        win(200, 30, 100);
        win(200, 30, 100);
        step(1);
        for (int i = 0; i < 20; i++) begin
            if (i == 2 || i == 5 || i == 8) win(-250, 0, 100);
            else step(1);
            n_checks++;
            if (gesture_valid !== 1'b1 || gesture_class !== 2'd0 || gesture_strength !== 18'd200)
                $display("FAIL hold_%0d got v%b c%0d s%0d exp v1 c0 s200", i, gesture_valid, gesture_class, gesture_strength);
            else n_pass++;
        end
        n_checks++;
        if (dropped_count !== 8'd3) $display("FAIL dropped got %0d exp 3", dropped_count);
        else n_pass++;
        gesture_ready = 1'b1;
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b0 || busy !== 1'b1 || hs_count - h0 != 1)
            $display("FAIL bp_release got v%b busy%b hs %0d exp v0 busy1 hs1", gesture_valid, busy, hs_count - h0);
        else n_pass++;
        win(-250, 0, 100);
        win(-250, 0, 100);
        win(-250, 0, 100);
        step(2);
        n_checks++;
        if (gesture_valid !== 1'b0 || busy !== 1'b0 || hs_count - h0 != 1 || dropped_count !== 8'd3)
            $display("FAIL cooldown got v%b busy%b hs %0d drop %0d exp v0 busy0 hs1 drop3",
                     gesture_valid, busy, hs_count - h0, dropped_count);
        else n_pass++;
        win(300, 10, 100);
        win(300, 10, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd0 || gesture_strength !== 18'd300)
            $display("FAIL post_cooldown got v%b c%0d s%0d exp v1 c0 s300", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        flush();
    endtask

    task automatic test_reset_mid_emit();
        gesture_ready = 1'b0;
        win(200, 30, 100);
        win(200, 30, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1) $display("FAIL pre_reset_valid got %b exp 1", gesture_valid);
        else n_pass++;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        n_checks++;
        if (gesture_valid !== 1'b0 || dropped_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL mid_reset got v%b drop %0d busy%b exp v0 drop0 busy0", gesture_valid, dropped_count, busy);
        else n_pass++;
        gesture_ready = 1'b1;
        win(150, 20, 100);
        win(150, 20, 100);
        step(1);
        n_checks++;
        if (gesture_valid !== 1'b1 || gesture_class !== 2'd0 || gesture_strength !== 18'd150)
            $display("FAIL after_reset got v%b c%0d s%0d exp v1 c0 s150", gesture_valid, gesture_class, gesture_strength);
        else n_pass++;
        step(1);
        flush();
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        delta_x       = 18'sd0;
        delta_y       = 18'sd0;
        abs_delta_x   = 18'd0;
        abs_delta_y   = 18'd0;
        total_events  = 12'd0;
        gesture_ready = 1'b0;
        test_reset();
        test_basic_right();
        test_min_events();
        test_dominance();
        test_class_change();
        test_backpressure();
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
